// File: rtl/arc4_ksa.sv
// ARC4 key-scheduling stage: permutes the identity S array held in an external
// 256x8 single-port RAM in place, using a 24-bit key.
//
// state | meaning
// IDLE  | rdy=1, waiting for en
// RD_I  | present addr=i to the RAM
// CAP_I | latch S[i], advance j
// RD_J  | present addr=j to the RAM
// CAP_J | latch S[j] straight into the write-data register
// WR_I  | S[i] <= S[j]
// WR_J  | S[j] <= S[i], step i or finish
module arc4_ksa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    RD_J  = 3'd3,
    CAP_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  i, j, si, kb;
  logic [1:0]  phase;  // i mod 3, tracked incrementally to avoid a divider

  always_comb begin
    case (phase)
      2'd0:    kb = key[23:16];
      2'd1:    kb = key[15:8];
      default: kb = key[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      i      <= 8'h00;
      j      <= 8'h00;
      si     <= 8'h00;
      phase  <= 2'd0;
      wrdata <= 8'h00;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (en) begin
            i     <= 8'h00;
            j     <= 8'h00;
            phase <= 2'd0;
          end
        end
        CAP_I: begin
          si <= rddata;
          j  <= j + rddata + kb;
        end
        // wrdata doubles as the S[j] holding register
        CAP_J: wrdata <= rddata;
        WR_I:  wrdata <= si;
        WR_J: begin
          if (i != 8'hFF) begin
            i     <= i + 8'd1;
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    wren     = 1'b0;
    addr     = 8'h00;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nx = RD_I;
      end
      RD_I: begin
        addr     = i;
        state_nx = CAP_I;
      end
      CAP_I: begin
        addr     = i;
        state_nx = RD_J;
      end
      RD_J: begin
        addr     = j;
        state_nx = CAP_J;
      end
      CAP_J: begin
        addr     = j;
        state_nx = WR_I;
      end
      WR_I: begin
        addr     = i;
        wren     = 1'b1;
        state_nx = WR_J;
      end
      WR_J: begin
        addr     = j;
        wren     = 1'b1;
        state_nx = (i == 8'hFF) ? IDLE : RD_I;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_ksa.sv
// Bench for arc4_ksa: behavioural S-RAM, write scoreboard fed by a software KSA
// model, and directed scenarios for reset, timing, handshake and restarts.
module tb_arc4_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  logic [7:0]  mem [256];
  logic [7:0]  load_img [256];
  logic [7:0]  ms [256];
  logic [7:0]  rd_q = 8'h00;
  logic        load = 1'b0;
  logic        const_mode = 1'b0;

  logic [15:0] exp_q [$];
  logic [15:0] wlog [$];
  int          tot_wr = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  arc4_ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 256; k++) mem[k] <= load_img[k];
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rd_q <= mem[addr];
  end

  assign rddata = const_mode ? 8'h01 : rd_q;

  // scoreboard consumer: every DUT write must match the next modelled write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wren === 1'b1) begin
      logic [15:0] e;
      wlog.push_back({addr, wrdata});
      tot_wr++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_empty: got write %h expected none", {addr, wrdata});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        assert ({addr, wrdata} === e) else begin
          n_bad++;
          $error("FAIL sb_write: got %h expected %h", {addr, wrdata}, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ksa_model(input logic [23:0] k);
    logic [7:0] jj, t, kb;
    jj = 8'h00;
    for (int ii = 0; ii < 256; ii++) begin
      case (ii % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      jj = jj + ms[ii] + kb;
      exp_q.push_back({ii[7:0], ms[jj]});
      exp_q.push_back({jj, ms[ii]});
      t      = ms[ii];
      ms[ii] = ms[jj];
      ms[jj] = t;
    end
  endtask

  task automatic load_identity();
    for (int k = 0; k < 256; k++) begin
      load_img[k] = k[7:0];
      ms[k]       = k[7:0];
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int busy);
    busy = 0;
    while (rdy === 1'b0 && busy < 2000) begin
      busy++;
      if (toggle) en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // starts at a negedge with the DUT idle; returns at the negedge rdy is back
  task automatic run(input bit toggle, input bit hold, output int busy);
    en = 1'b1;
    @(negedge clk);
    if (!hold) en = 1'b0;
    wait_done(toggle, busy);
    if (!hold) en = 1'b0;
  endtask

  task automatic chk_ram(input string tag);
    int diff;
    diff = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ms[k]) diff++;
    chk(tag, diff, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, busy2, base;

    rst_n = 1'b0;
    en    = 1'b0;
    key   = 24'h000000;
    @(negedge clk);
    chk("rst_addr", addr, 8'h00);
    chk("rst_wrdata", wrdata, 8'h00);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("idle_rdy", rdy, 1'b1);
      chk("idle_wren", wren, 1'b0);
      @(negedge clk);
    end

    // constant-read stub
    const_mode = 1'b1;
    key = 24'h000002;
    for (int k = 0; k < 256; k++) ms[k] = 8'h01;
    ksa_model(key);
    base = tot_wr;
    run(1'b0, 1'b0, busy);
    #1;
    chk("stub_busy", busy, 1536);
    chk("stub_writes", tot_wr - base, 512);
    chk("stub_w0", wlog[base + 0], 16'h0001);
    chk("stub_w1", wlog[base + 1], 16'h0101);
    chk("stub_w2", wlog[base + 2], 16'h0101);
    chk("stub_w3", wlog[base + 3], 16'h0201);
    chk("stub_w4", wlog[base + 4], 16'h0201);
    chk("stub_w5", wlog[base + 5], 16'h0501);
    chk("stub_sb_drained", exp_q.size(), 0);
    const_mode = 1'b0;

    // identity memory, en toggled randomly while busy
    load_identity();
    key = 24'h1E4600;
    ksa_model(key);
    base = tot_wr;
    run(1'b1, 1'b0, busy);
    #1;
    chk("id_busy", busy, 1536);
    chk("id_writes", tot_wr - base, 512);
    chk("id_w0", wlog[base + 0], 16'h001E);
    chk("id_w1", wlog[base + 1], 16'h1E00);
    chk("id_sb_drained", exp_q.size(), 0);
    chk_ram("id_final_ram");
    @(negedge clk);
    chk("id_stays_idle", rdy, 1'b1);

    // reset during iteration 100, then restart on the partly permuted RAM
    load_identity();
    key = 24'hA5C30F;
    ksa_model(key);
    base = tot_wr;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 5000 && (tot_wr - base) < 200; c++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_reached_iter100", tot_wr - base, 200);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wren", wren, 1'b0);
    chk("mid_rst_rdy", rdy, 1'b1);
    rst_n = 1'b1;
    exp_q.delete();
    base = tot_wr;
    @(negedge clk);
    #1;
    chk("mid_no_write_after_rst", tot_wr - base, 0);
    for (int k = 0; k < 256; k++) ms[k] = mem[k];
    ksa_model(key);
    base = tot_wr;
    @(negedge clk);
    run(1'b0, 1'b0, busy);
    #1;
    chk("restart_busy", busy, 1536);
    chk("restart_writes", tot_wr - base, 512);
    chk("restart_sb_drained", exp_q.size(), 0);
    chk_ram("restart_final_ram");

    // back-to-back runs with en held high
    load_identity();
    key = 24'hFFFFFF;
    ksa_model(key);
    ksa_model(key);
    base = tot_wr;
    run(1'b0, 1'b1, busy);
    chk("b2b_busy1", busy, 1536);
    chk("b2b_rdy_between", rdy, 1'b1);
    @(negedge clk);
    chk("b2b_restart", rdy, 1'b0);
    en = 1'b0;
    wait_done(1'b0, busy2);
    #1;
    chk("b2b_busy2", busy2, 1536);
    chk("b2b_writes", tot_wr - base, 1024);
    chk("b2b_sb_drained", exp_q.size(), 0);
    chk_ram("b2b_final_ram");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arc4_ksa.md
Name: arc4_ksa

Overview:
- Key-scheduling stage of the ARC4 decryption circuit.
- Applies the ARC4 KSA permutation in place to a 256-byte S array held in an external single-port RAM, using a 24-bit key.
- The RAM has already been filled with the identity (S[i]=i) by the init stage.
- A top-level controller starts this block with a ready/enable handshake; the PRGA stage runs after it.

Parameters:
- None. Key width is fixed at 24 bits and memory depth at 256 x 8.

Ports:
- clk     input   1   system clock; all logic on rising edge
- rst_n   input   1   synchronous active-low reset
- en      input   1   start request; sampled only while rdy=1
- rdy     output  1   1 = idle and able to accept en
- key     input   24  ARC4 key; must be held stable while busy
- addr    output  8   S-RAM address
- rddata  input   8   S-RAM read data, valid the cycle after addr is presented
- wrdata  output  8   S-RAM write data
- wren    output  1   S-RAM write enable, active high

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, rdy=1, wren=0, addr=0, wrdata=0.
  - Internal i=0, j=0.
  - Reset mid-operation aborts immediately: no further writes, and rdy=1 on the following cycle.
- Algorithm:
  - j=0.
  - For i=0..255: j=(j+S[i]+kb) mod 256, then swap S[i] and S[j].
  - kb=key[23:16] when i mod 3=0, key[15:8] when i mod 3=1, key[7:0] when i mod 3=2.
  - All arithmetic is 8-bit with wrap-around.
- Handshake:
  - In IDLE, en=1 at a rising edge clears i and j, moves to RD_I, and drops rdy the next cycle.
  - en is ignored while rdy=0.
  - en held high after completion starts a new run.
- FSM, one cycle per state:
  - IDLE: rdy=1, wren=0.
  - RD_I: addr=i, wren=0.
  - CAP_I: capture si=rddata; compute j=j+si+kb; addr=i, wren=0.
  - RD_J: addr=j (new j), wren=0.
  - CAP_J: capture sj=rddata; wren=0.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1. If i=255, go to IDLE; else i=i+1 and go to RD_I.
- Timing:
  - 6 cycles per iteration, 1536 busy cycles total.
  - rdy=0 for exactly 1536 cycles; rdy returns high the cycle after the final WR_J.
- Boundary conditions:
  - i=j: both writes store the same value; the result is correct with no special case.
  - j wraps mod 256.
  - The i counter must detect 255 without overflowing into an extra iteration.
- Outside the write states:
  - wren=0 always.
  - wrdata holds its last value and is don't-care.
- No combinational path from rddata to wren.

Test Plan:
- Reset check:
  - Stimulus: rst_n=0 for one edge, en=0.
  - Required: rdy=1 and wren=0; both stay unchanged for 10 cycles.
- Constant-read stub:
  - Stimulus: rddata tied to 1, key=0x000002, pulse en one cycle.
  - Required for i=0: addr=0 then j=1.
  - Writes: addr0<=1, then addr1<=1.
  - For i=1: j=1+1+0=2.
  - For i=2: j=2+1+2=5.
- Identity memory model, key=0x1E4600:
  - Stimulus: bench RAM initialised to S[i]=i, run to completion.
  - Required: first writes are S[0]<=0x1E, then S[0x1E]<=0x00.
  - Final RAM contents match a software KSA model byte-for-byte.
- Latency and handshake:
  - Stimulus: count cycles from the en-accept edge.
  - Required: rdy low for exactly 1536 cycles.
  - Toggling en while busy changes nothing.
  - Exactly 512 cycles have wren=1.
- Reset mid-run:
  - Stimulus: assert rst_n=0 at iteration 100.
  - Required: wren=0 and rdy=1 next cycle.
  - A subsequent en restarts from i=0, j=0.
- Back-to-back runs:
  - Stimulus: hold en=1 through completion with key=0xFFFFFF.
  - Required: a second run starts the cycle after rdy rises; the result matches a model applying KSA twice.
